// File: rtl/trail_ctrl.sv
// trail_ctrl: sequencer for the solver assignment trail stack.
// Pushes assignments (tagging decisions and tracking the decision level),
// backtracks to a target level by popping and streaming variables to the
// unassign consumer, and wipes the trail on request.
module trail_ctrl #(
    parameter int VAR_W = 16,
    parameter int DEPTH = 64,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             assign_valid,
    output logic             assign_ready,
    input  logic [VAR_W-1:0] assign_var,
    input  logic             assign_val,
    input  logic             assign_dec,
    input  logic             bt_valid,
    input  logic [LVL_W-1:0] bt_level,
    output logic             bt_done,
    input  logic             clear_req,
    output logic             clear_done,
    output logic             unassign_valid,
    input  logic             unassign_ready,
    output logic [VAR_W-1:0] unassign_var,
    output logic [LVL_W-1:0] cur_level,
    output logic             busy,
    output logic             level_ovf,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_clear,
    output logic [VAR_W+1:0] stk_push_data,
    input  logic [VAR_W+1:0] stk_top_data,
    input  logic             stk_full,
    input  logic             stk_empty
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POP   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_MAX  = {LVL_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [LVL_W-1:0] cur_level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic [LVL_W-1:0] bt_level_r;
    logic [LVL_W-1:0] bt_level_nxt_s;
    logic [LVL_W-1:0] pop_level_s;
    logic             level_ovf_r;
    logic             ovf_nxt_s;
    logic             assign_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             clear_s;
    logic             unassign_valid_s;
    logic             bt_done_s;
    logic             clear_done_s;

    // Next-state, level bookkeeping and stack strobe decode
    always_comb begin
        state_nxt_s      = state_r;
        level_nxt_s      = cur_level_r;
        bt_level_nxt_s   = bt_level_r;
        ovf_nxt_s        = level_ovf_r;
        pop_level_s      = cur_level_r;
        assign_ready_s   = 1'b0;
        push_s           = 1'b0;
        pop_s            = 1'b0;
        clear_s          = 1'b0;
        unassign_valid_s = 1'b0;
        bt_done_s        = 1'b0;
        clear_done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt_s = ST_CLEAR;
                end else if (bt_valid) begin
                    // Target is latched so the requester may change bt_level later
                    bt_level_nxt_s = bt_level;
                    if (bt_level >= cur_level_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_POP;
                    end
                end else begin
                    assign_ready_s = !stk_full;
                    if (assign_valid && !stk_full) begin
                        push_s = 1'b1;
                        if (assign_dec) begin
                            // Saturate rather than wrap; the sticky flag records the loss
                            if (cur_level_r == LVL_MAX) begin
                                ovf_nxt_s = 1'b1;
                            end else begin
                                level_nxt_s = cur_level_r + LVL_ONE;
                            end
                        end else begin
                            level_nxt_s = cur_level_r;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                end
            end
            ST_POP: begin
                if (stk_empty) begin
                    // Trail ran out before reaching the target: trust the target
                    level_nxt_s = bt_level_r;
                    state_nxt_s = ST_DONE;
                end else begin
                    unassign_valid_s = 1'b1;
                    if (unassign_ready) begin
                        pop_s = 1'b1;
                        if (stk_top_data[VAR_W+1] && (cur_level_r != LVL_ZERO)) begin
                            pop_level_s = cur_level_r - LVL_ONE;
                        end else begin
                            pop_level_s = cur_level_r;
                        end
                        level_nxt_s = pop_level_s;
                        if (pop_level_s == bt_level_r) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_POP;
                        end
                    end else begin
                        pop_s = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                bt_done_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: begin
                clear_s      = 1'b1;
                clear_done_s = 1'b1;
                level_nxt_s  = LVL_ZERO;
                ovf_nxt_s    = 1'b0;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cur_level_r <= LVL_ZERO;
            bt_level_r  <= LVL_ZERO;
            level_ovf_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cur_level_r <= level_nxt_s;
            bt_level_r  <= bt_level_nxt_s;
            level_ovf_r <= ovf_nxt_s;
        end
    end

    assign assign_ready   = assign_ready_s;
    assign stk_push       = push_s;
    assign stk_pop        = pop_s;
    assign stk_clear      = clear_s;
    assign stk_push_data  = {assign_dec, assign_val, assign_var};
    assign unassign_valid = unassign_valid_s;
    assign unassign_var   = stk_top_data[VAR_W-1:0];
    assign bt_done        = bt_done_s;
    assign clear_done     = clear_done_s;
    assign cur_level      = cur_level_r;
    assign busy           = (state_r != ST_IDLE);
    assign level_ovf      = level_ovf_r;

endmodule

// File: tb/tb_trail_ctrl.sv
// Directed testbench for trail_ctrl with a behavioural trail stack attached.
module tb_trail_ctrl;

    localparam int VAR_W = 16;
    localparam int DEPTH = 64;
    localparam int LVL_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             assign_valid = 1'b0;
    logic             assign_ready;
    logic [VAR_W-1:0] assign_var = 16'd0;
    logic             assign_val = 1'b0;
    logic             assign_dec = 1'b0;
    logic             bt_valid = 1'b0;
    logic [LVL_W-1:0] bt_level = 7'd0;
    logic             bt_done;
    logic             clear_req = 1'b0;
    logic             clear_done;
    logic             unassign_valid;
    logic             unassign_ready = 1'b0;
    logic [VAR_W-1:0] unassign_var;
    logic [LVL_W-1:0] cur_level;
    logic             busy;
    logic             level_ovf;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_clear;
    logic [VAR_W+1:0] stk_push_data;
    logic [VAR_W+1:0] stk_top_data;
    logic             stk_full;
    logic             stk_empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural trail stack (not reset by rst_n)
    logic [VAR_W+1:0] mem [DEPTH];
    logic [6:0]       stk_cnt = 7'd0;

    assign stk_full     = (stk_cnt == 7'd64);
    assign stk_empty    = (stk_cnt == 7'd0);
    assign stk_top_data = (stk_cnt != 7'd0) ? mem[stk_cnt - 7'd1] : 18'd0;

    always #5 clk = ~clk;

    // Stack model update
    always @(posedge clk) begin
        if (stk_clear) begin
            stk_cnt <= 7'd0;
        end else if (stk_push && !stk_full) begin
            mem[stk_cnt[5:0]] <= stk_push_data;
            stk_cnt <= stk_cnt + 7'd1;
        end else if (stk_pop && !stk_empty) begin
            stk_cnt <= stk_cnt - 7'd1;
        end
    end

    trail_ctrl #(.VAR_W(VAR_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .assign_valid(assign_valid), .assign_ready(assign_ready),
        .assign_var(assign_var), .assign_val(assign_val), .assign_dec(assign_dec),
        .bt_valid(bt_valid), .bt_level(bt_level), .bt_done(bt_done),
        .clear_req(clear_req), .clear_done(clear_done),
        .unassign_valid(unassign_valid), .unassign_ready(unassign_ready),
        .unassign_var(unassign_var), .cur_level(cur_level), .busy(busy),
        .level_ovf(level_ovf), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_clear(stk_clear), .stk_push_data(stk_push_data),
        .stk_top_data(stk_top_data), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    // Stimulus helper: one push; starts and ends 1 time unit after a rising edge
    task automatic do_push(input logic [15:0] v, input logic dec);
        assign_var   = v;
        assign_val   = v[0];
        assign_dec   = dec;
        assign_valid = 1'b1;
        @(posedge clk); #1;
        assign_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (cur_level !== 7'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", cur_level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
        n_checks++; if ({bt_done, clear_done, unassign_valid, stk_pop, stk_clear, level_ovf} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b exp 000000", {bt_done, clear_done, unassign_valid, stk_pop, stk_clear, level_ovf}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (assign_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %0b exp 1", assign_ready); end
    endtask

    task automatic test_push();
        assign_var = 16'd3; assign_val = 1'b1; assign_dec = 1'b1; assign_valid = 1'b1;
        #1;
        n_checks++; if (stk_push !== 1'b1) begin n_fail++; $display("FAIL push_strobe got %0b exp 1", stk_push); end
        n_checks++; if (stk_push_data !== 18'h30003) begin n_fail++; $display("FAIL push_data got %h exp 30003", stk_push_data); end
        @(posedge clk); #1;
        assign_valid = 1'b0;
        n_checks++; if (cur_level !== 7'd1) begin n_fail++; $display("FAIL push_level1 got %0d exp 1", cur_level); end
        do_push(16'd4, 1'b0);
        do_push(16'd5, 1'b0);
        do_push(16'd6, 1'b1);
        do_push(16'd7, 1'b0);
        n_checks++; if (cur_level !== 7'd2) begin n_fail++; $display("FAIL push_level got %0d exp 2", cur_level); end
        n_checks++; if (stk_cnt !== 7'd5) begin n_fail++; $display("FAIL push_count got %0d exp 5", stk_cnt); end
        n_checks++; if (stk_top_data[15:0] !== 16'd7) begin n_fail++; $display("FAIL push_top got %0d exp 7", stk_top_data[15:0]); end
    endtask

    task automatic test_bt_pop();
        bt_valid = 1'b1; bt_level = 7'd1; unassign_ready = 1'b1; assign_valid = 1'b1;
        #1;
        n_checks++; if ({assign_ready, stk_push} !== 2'b00) begin n_fail++; $display("FAIL bt_blocks_assign got %b exp 00", {assign_ready, stk_push}); end
        @(posedge clk); #1;
        assign_valid = 1'b0;
        n_checks++; if ({unassign_valid, stk_pop, unassign_var} !== {2'b11, 16'd7}) begin
            n_fail++; $display("FAIL pop_first got v=%0b p=%0b var=%0d exp 1 1 7", unassign_valid, stk_pop, unassign_var); end
        @(posedge clk); #1;
        n_checks++; if ({unassign_valid, stk_pop, unassign_var} !== {2'b11, 16'd6}) begin
            n_fail++; $display("FAIL pop_second got v=%0b p=%0b var=%0d exp 1 1 6", unassign_valid, stk_pop, unassign_var); end
        @(posedge clk); #1;
        n_checks++; if ({bt_done, unassign_valid, stk_pop} !== 3'b100) begin
            n_fail++; $display("FAIL pop_done got %b exp 100", {bt_done, unassign_valid, stk_pop}); end
        bt_valid = 1'b0; unassign_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({bt_done, busy} !== 2'b00) begin n_fail++; $display("FAIL pop_done_pulse got %b exp 00", {bt_done, busy}); end
        n_checks++; if (cur_level !== 7'd1) begin n_fail++; $display("FAIL pop_level got %0d exp 1", cur_level); end
        n_checks++; if ({stk_cnt, stk_top_data[15:0]} !== {7'd3, 16'd5}) begin
            n_fail++; $display("FAIL pop_stack got cnt=%0d top=%0d exp 3 5", stk_cnt, stk_top_data[15:0]); end
    endtask

    task automatic test_bt_noop();
        do_push(16'd8, 1'b1);
        n_checks++; if (cur_level !== 7'd2) begin n_fail++; $display("FAIL noop_pre_level got %0d exp 2", cur_level); end
        bt_valid = 1'b1; bt_level = 7'd3; unassign_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({bt_done, stk_pop, unassign_valid} !== 3'b100) begin
            n_fail++; $display("FAIL noop_done got %b exp 100", {bt_done, stk_pop, unassign_valid}); end
        bt_valid = 1'b0; unassign_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({cur_level, stk_cnt} !== {7'd2, 7'd4}) begin
            n_fail++; $display("FAIL noop_state got lvl=%0d cnt=%0d exp 2 4", cur_level, stk_cnt); end
    endtask

    task automatic test_bt_stall();
        logic [15:0] exp_seq [4];
        logic [15:0] held;
        logic        stalled;
        int          idx;
        logic        done;
        exp_seq[0] = 16'd8; exp_seq[1] = 16'd5; exp_seq[2] = 16'd4; exp_seq[3] = 16'd3;
        idx = 0; done = 1'b0; stalled = 1'b0; held = 16'd0;
        bt_valid = 1'b1; bt_level = 7'd0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            unassign_ready = (cyc % 2 == 1);
            #1;
            if (bt_done) begin
                done = 1'b1;
                break;
            end
            if (unassign_valid) begin
                if (stalled) begin
                    n_checks++; if (unassign_var !== held) begin n_fail++; $display("FAIL stall_stable got %0d exp %0d", unassign_var, held); end
                end
                if (unassign_ready) begin
                    n_checks++;
                    if (idx >= 4) begin
                        n_fail++; $display("FAIL stall_extra got %0d exp none", unassign_var);
                    end else if (unassign_var !== exp_seq[idx]) begin
                        n_fail++; $display("FAIL stall_seq got %0d exp %0d", unassign_var, exp_seq[idx]);
                    end
                    idx++;
                end
                stalled = !unassign_ready;
                held = unassign_var;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_timeout got done=%0b exp 1", done); end
        n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL stall_count got %0d exp 4", idx); end
        bt_valid = 1'b0; unassign_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({cur_level, stk_cnt} !== {7'd0, 7'd0}) begin
            n_fail++; $display("FAIL stall_final got lvl=%0d cnt=%0d exp 0 0", cur_level, stk_cnt); end
    endtask

    task automatic test_full_clear();
        for (int i = 0; i < 64; i++) begin
            assign_var = 16'(i + 100); assign_val = 1'b0; assign_dec = (i % 8 == 0); assign_valid = 1'b1;
            @(posedge clk); #1;
        end
        assign_var = 16'd999; assign_dec = 1'b1;
        n_checks++; if ({stk_full, assign_ready, stk_push} !== 3'b100) begin
            n_fail++; $display("FAIL full_ready got %b exp 100", {stk_full, assign_ready, stk_push}); end
        n_checks++; if (cur_level !== 7'd8) begin n_fail++; $display("FAIL full_level got %0d exp 8", cur_level); end
        clear_req = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({stk_clear, clear_done, busy, stk_push} !== 4'b1110) begin
            n_fail++; $display("FAIL clear_pulse got %b exp 1110", {stk_clear, clear_done, busy, stk_push}); end
        clear_req = 1'b0; assign_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({stk_empty, clear_done, cur_level} !== {2'b10, 7'd0}) begin
            n_fail++; $display("FAIL clear_after got e=%0b cd=%0b lvl=%0d exp 1 0 0", stk_empty, clear_done, cur_level); end
        // Clear must also beat an assignment when the stack has room
        do_push(16'd20, 1'b1);
        clear_req = 1'b1; assign_valid = 1'b1; assign_var = 16'd21;
        #1;
        n_checks++; if ({assign_ready, stk_push} !== 2'b00) begin n_fail++; $display("FAIL clear_wins got %b exp 00", {assign_ready, stk_push}); end
        @(posedge clk); #1;
        clear_req = 1'b0; assign_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({stk_cnt, cur_level} !== {7'd0, 7'd0}) begin
            n_fail++; $display("FAIL clear_wins_after got cnt=%0d lvl=%0d exp 0 0", stk_cnt, cur_level); end
    endtask

    task automatic test_reset_mid_pop();
        do_push(16'd10, 1'b1);
        do_push(16'd11, 1'b0);
        do_push(16'd12, 1'b0);
        do_push(16'd13, 1'b0);
        bt_valid = 1'b1; bt_level = 7'd0; unassign_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if ({unassign_valid, unassign_var, stk_cnt} !== {1'b1, 16'd11, 7'd2}) begin
            n_fail++; $display("FAIL rst_pre got v=%0b var=%0d cnt=%0d exp 1 11 2", unassign_valid, unassign_var, stk_cnt); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({unassign_valid, stk_pop, busy, cur_level} !== {3'b000, 7'd0}) begin
            n_fail++; $display("FAIL rst_mid got v=%0b p=%0b b=%0b lvl=%0d exp 0 0 0 0", unassign_valid, stk_pop, busy, cur_level); end
        bt_valid = 1'b0; unassign_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({stk_cnt, stk_top_data[15:0], level_ovf} !== {7'd2, 16'd11, 1'b0}) begin
            n_fail++; $display("FAIL rst_retain got cnt=%0d top=%0d ovf=%0b exp 2 11 0", stk_cnt, stk_top_data[15:0], level_ovf); end
    endtask

    // Sequencer
    initial begin
        test_reset();
        test_push();
        test_bt_pop();
        test_bt_noop();
        test_bt_stall();
        test_full_clear();
        test_reset_mid_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
